// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for MIPS DIV/DIVU
// Returns {HI=remainder, LO=quotient} after WIDTH iterations, raising a pipeline stall while busy.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t            state, next_state;
  logic [2*WIDTH:0]  work;
  logic [2*WIDTH:0]  shifted;
  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  divisor;
  logic [CW-1:0]     cnt;
  logic              neg_q, neg_r;
  logic [WIDTH-1:0]  mag1, mag2;
  logic [WIDTH-1:0]  quo, rem, quo_fix, rem_fix;

  // Operand magnitudes are taken at latch time; later operand changes are ignored.
  always_comb begin
    mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  always_comb begin
    shifted = work << 1;
    diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
    quo     = work[WIDTH-1:0];
    rem     = work[2*WIDTH-1:WIDTH];
    quo_fix = neg_q ? -quo : quo;
    rem_fix = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FREE;
      work    <= '0;
      cnt     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        S_FREE: begin
          if (start_i && !annul_i) begin
            work    <= {{(WIDTH+1){1'b0}}, mag1};
            divisor <= mag2;
            neg_q   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r   <= signed_div_i && opdata1_i[WIDTH-1];
            cnt     <= '0;
          end
        end
        S_BYZERO: work <= '0;
        S_ON: begin
          if (!annul_i) begin
            // Negative trial difference means the divisor did not fit: keep the shifted value.
            if (diff[WIDTH])
              work <= shifted;
            else
              work <= {diff, shifted[WIDTH-1:1], 1'b1};
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    ready_o    = 1'b0;
    stallreq_o = 1'b0;
    result_o   = '0;
    case (state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          stallreq_o = 1'b1;
          next_state = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        stallreq_o = 1'b1;
        next_state = S_END;
      end
      S_ON: begin
        stallreq_o = 1'b1;
        if (annul_i)
          next_state = S_FREE;
        else if (cnt == CW'(WIDTH - 1))
          next_state = S_END;
      end
      S_END: begin
        ready_o  = 1'b1;
        result_o = {rem_fix, quo_fix};
        if (annul_i || !start_i)
          next_state = S_FREE;
      end
      default: next_state = S_FREE;
    endcase
    if (annul_i)
      stallreq_o = 1'b0;
    if (rst) begin
      ready_o    = 1'b0;
      stallreq_o = 1'b0;
      result_o   = '0;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
// Directed and random divisions compared against an integer-arithmetic reference.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks = 0;
  int failures = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating integer division; remainder follows dividend sign; /0 gives 0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint qa, qb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
    end else begin
      qa = {32'd0, a};
      qb = {32'd0, b};
    end
    q = qa / qb;
    r = qa % qb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input string tag);
    logic [63:0] exp;
    int n;
    int stall_bad;
    exp = ref_div(a, b, s);
    opdata1 = a;
    opdata2 = b;
    signed_div = s;
    start = 1'b1;
    #1;
    chk({tag, " stall_at_start"}, {63'd0, stallreq}, 64'd1);
    n = 0;
    stall_bad = 0;
    while (!ready && n < 40) begin
      cycle();
      n++;
      if (!ready && !stallreq) stall_bad++;
      opdata1 = $urandom;
      opdata2 = $urandom;
      signed_div = 1'($urandom_range(0, 1));
    end
    chk({tag, " latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
    chk({tag, " stall_while_busy"}, 64'(stall_bad), 64'd0);
    chk({tag, " ready"}, {63'd0, ready}, 64'd1);
    chk({tag, " stall_at_ready"}, {63'd0, stallreq}, 64'd0);
    chk({tag, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      cycle();
      chk({tag, " hold_ready"}, {63'd0, ready}, 64'd1);
      chk({tag, " hold_result"}, result, exp);
    end
    start = 1'b0;
    cycle();
    chk({tag, " ready_drop"}, {63'd0, ready}, 64'd0);
    chk({tag, " result_cleared"}, result, 64'd0);
  endtask

  initial begin : stim
    int seen;
    logic [31:0] ra, rb;
    logic rs;

    // Reset: outputs forced low even with start asserted.
    start = 1'b1;
    opdata1 = 32'd10;
    opdata2 = 32'd3;
    cycle();
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_stall", {63'd0, stallreq}, 64'd0);
    chk("reset_result", result, 64'd0);
    start = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("idle_ready", {63'd0, ready}, 64'd0);
    chk("idle_stall", {63'd0, stallreq}, 64'd0);

    run_div(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div_7_m2");
    run_div(32'd5, 32'd0, 1'b0, 0, "div_by_zero");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_min_m1");

    // Annul with start asserted in FREE suppresses the stall request.
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    #1;
    chk("annul_free_stall", {63'd0, stallreq}, 64'd0);
    cycle();
    chk("annul_free_no_ready", {63'd0, ready}, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    cycle();

    // Annul mid-division at T+10.
    opdata1 = 32'd500;
    opdata2 = 32'd7;
    signed_div = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    annul = 1'b1;
    start = 1'b0;
    #1;
    chk("annul_on_stall", {63'd0, stallreq}, 64'd0);
    cycle();
    annul = 1'b0;
    #1;
    chk("annul_after_ready", {63'd0, ready}, 64'd0);
    chk("annul_after_stall", {63'd0, stallreq}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (ready || stallreq) seen++;
    end
    chk("annul_no_late_activity", 64'(seen), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, 0, "after_annul_9_3");

    // Reset at T+15 abandons the division.
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    start = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_stall", {63'd0, stallreq}, 64'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_next_ready", {63'd0, ready}, 64'd0);
    chk("rst_next_stall", {63'd0, stallreq}, 64'd0);
    chk("rst_next_result", result, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (ready) seen++;
    end
    chk("rst_no_stale_ready", 64'(seen), 64'd0);
    run_div(32'd12345, 32'd67, 1'b0, 0, "after_rst");

    // Hold start in END, then an immediate back-to-back DIVU.
    run_div(32'hFFFF_FF9C, 32'd9, 1'b1, 3, "hold_end");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "divu_max_1");

    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0)
        rb = 32'd0;
      else if ($urandom_range(0, 1) == 1)
        rb = $urandom;
      else
        rb = $urandom_range(1, 50);
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, int'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit radix-2 divider instantiated beside EX. It executes MIPS DIV/DIVU over 32 iteration cycles. While busy it raises a stall request toward the pipeline controller, which drives the controller's `stallreq_for_ex` input and is converted to stall bus `6'b001111` (PC, IF, ID, EX held). It returns a 64-bit {HI, LO} result with a one-signal ready handshake.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals WIDTH.

Ports:
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `signed_div_i`  in  1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i`  in  WIDTH: dividend.
- `opdata2_i`  in  WIDTH: divisor.
- `start_i`  in  1: request. EX holds it high until it observes `ready_o`=1.
- `annul_i`  in  1: abort the current or pending division (exception/flush).
- `result_o`  out  2*WIDTH: {remainder (HI), quotient (LO)}.
- `ready_o`  out  1: result valid.
- `stallreq_o`  out  1: stall request to the controller.

## Operation
States and transitions:
- FREE: idle.
  - `start_i` & !`annul_i` & divisor==0 → BYZERO.
  - `start_i` & !`annul_i` & divisor!=0 → ON.
  - In both cases, latch the operands and sign mode and clear the counter.
  - Otherwise stay in FREE.
- BYZERO: → END, with the result forced to 0 (HI=0, LO=0).
- ON: one shift-subtract iteration per cycle.
  - `annul_i`=1 → FREE. The partial result is discarded.
  - After the iteration with counter==WIDTH-1 → END.
- END: `ready_o`=1 and `result_o` is valid.
  - `start_i`=0 → FREE.
  - `start_i`=1 → stay in END and hold the result. This covers EX being held by a later-stage stall.
  - `annul_i`=1 → FREE.

Arithmetic:
- Restoring division on magnitudes, using a (2*WIDTH+1)-bit working register.
- Signed mode converts negative operands to two's-complement magnitude at latch time.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- Unsigned mode uses the operands unmodified.
- 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0. This is the natural wrap; no trap.
- `result_o` is driven from the final registers only in END. It is 0 in every other state.

Stall request:
- `stallreq_o` = (FREE & `start_i` & !`annul_i`) | ON | BYZERO.
- It is 0 in END, so the pipeline advances in the cycle `ready_o` is seen.
- `annul_i` forces `stallreq_o`=0 combinationally in every state.

Reset:
- `rst`=1 at any edge → FREE, counter 0, working register 0.
- All outputs are 0 in the reset cycle: `result_o`=0, `ready_o`=0, `stallreq_o`=0.
- Reset mid-division abandons it silently.

## Timing
- Cycle T: FREE samples `start_i`=1. `stallreq_o`=1 combinationally in T.
- Nonzero divisor:
  - ON occupies cycles T+1 … T+WIDTH.
  - END is reached at T+WIDTH+1, which is T+33 for WIDTH=32.
  - `ready_o`=1 and `stallreq_o`=0 in that cycle.
- Zero divisor: BYZERO at T+1, END (`ready_o`=1) at T+2.
- Operand inputs are ignored after cycle T. Changing them mid-operation has no effect.
- Back-to-back: if `start_i` drops in the END cycle, FREE follows. A new `start_i` is sampled the next cycle, so the minimum start-to-start spacing is WIDTH+2 cycles.
- `ready_o` is high for exactly one cycle unless `start_i` is held in END. In that case it remains high with a stable result.

## Test plan
- Unsigned: 100 / 7 with `start_i` at T → `ready_o` at T+33, `result_o` = {0x00000002, 0x0000000E}. `stallreq_o`=1 for T…T+32 and 0 at T+33.
- Signed: -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also cover 7 / -2 → LO=0xFFFFFFFD, HI=0x00000001.
- Divide by zero: 5 / 0 → `ready_o` at T+2, `result_o`=0. Edge case: 0x80000000 / 0xFFFFFFFF signed → {0, 0x80000000}.
- Annul: pulse `annul_i` at T+10 → FREE at T+11, `ready_o` never asserts, `stallreq_o`=0. A fresh 9 / 3 completes correctly with {0, 3}.
- Reset mid-op: `rst` at T+15 → all outputs 0 next cycle. No stale `ready_o` after release. A subsequent division is correct.
- Hold in END: keep `start_i` high 3 cycles past ready → `ready_o` and `result_o` stable for all 3 cycles. Dropping `start_i` returns to FREE. A DIVU 0xFFFFFFFF / 1 started immediately after gives {0, 0xFFFFFFFF}.
